tt_um_div_4: RTL and testbench

TT_UM_DIV_4 -- requirements
Module: tt_um_div_4

---
 rtl/div_4_pkg.sv | 21 ++
 rtl/div_4_dp.sv | 63 ++++++
 rtl/tt_um_div_4.sv | 123 ++++++++++++
 tb/tb_tt_um_div_4.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/div_4_pkg.sv
// Shared definitions for the 8-bit by 4-bit restoring divider tile.
package div_4_pkg;

    localparam int DVD_W = 8;  // dividend / quotient width
    localparam int DVS_W = 4;  // divisor / remainder width
    localparam int ITER  = 8;  // one iteration per quotient bit
    localparam int CNT_W = 4;  // iteration counter width, must hold ITER

    // Results reported when the divisor is zero.
    localparam logic [DVD_W-1:0] DZ_Q = 8'hFF;
    localparam logic [DVS_W-1:0] DZ_R = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SUB,
        DONE
    } state_e;

endpackage

// File: rtl/div_4_dp.sv
// Restoring-division datapath: working register {rem, dvd}, held divisor and
// iteration counter. The dividend is shifted out of dvd while quotient bits
// are shifted in from the bottom, so dvd holds the quotient at the end.
module div_4_dp
    import div_4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             sub,
    input  logic [DVD_W-1:0] dd,
    input  logic [DVS_W-1:0] dr,
    output logic             last,
    output logic [DVD_W-1:0] quo_nxt,
    output logic [DVS_W-1:0] rem_nxt
);

    // The partial remainder carries one extra bit: right after a shift it can
    // reach 2*DR-1, which needs DVS_W+1 bits before the subtract.
    logic [DVS_W:0]   rem_q;
    logic [DVD_W-1:0] dvd_q;
    logic [DVS_W-1:0] dr_q;
    logic [CNT_W-1:0] cnt_q;

    logic             ge;
    logic [DVS_W:0]   rem_sub;

    // Trial subtract of the shifted remainder; restore by keeping the old value.
    always_comb begin
        ge      = (rem_q >= {1'b0, dr_q});
        rem_sub = ge ? (rem_q - {1'b0, dr_q}) : rem_q;
    end

    // After a subtract the remainder is below DR, so it fits in DVS_W bits.
    assign rem_nxt = rem_sub[DVS_W-1:0];
    assign quo_nxt = {dvd_q[DVD_W-1:1], ge};
    assign last    = (cnt_q == CNT_W'(ITER - 1));

    // Working register and counter update, one operation per FSM step.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values, independent of statement order.
        if (rst) begin
            rem_q <= '0;
            dvd_q <= '0;
            dr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            dvd_q <= dd;
            dr_q  <= dr;
            cnt_q <= '0;
        end else if (shift) begin
            {rem_q, dvd_q} <= {rem_q[DVS_W-1:0], dvd_q, 1'b0};
        end else if (sub) begin
            rem_q    <= rem_sub;
            dvd_q[0] <= ge;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tt_um_div_4.sv
// Tiny Tapeout tile wrapper: start-edge detection, control FSM, result
// registers and pin mapping around the restoring-division datapath.
module tt_um_div_4
    import div_4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    input  logic       ena,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e           state_q, state_d;
    logic             init_q;
    logic             start;
    logic [DVS_W-1:0] dr_in;

    logic             dp_load, dp_shift, dp_sub, dp_last;
    logic [DVD_W-1:0] quo_nxt;
    logic [DVS_W-1:0] rem_nxt;

    logic [DVD_W-1:0] quo_q;
    logic [DVS_W-1:0] rem_q;
    logic             done_q, err_q;

    // Tile enable and the spare uio_in bits have no function here.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[3:1]};

    assign dr_in = uio_in[7:4];
    assign start = uio_in[0] & ~init_q;

    // Delayed copy of init for rising-edge start detection.
    always_ff @(posedge clk) begin
        if (rst) init_q <= 1'b0;
        else     init_q <= uio_in[0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        state_d  = state_q;
        dp_load  = 1'b0;
        dp_shift = 1'b0;
        dp_sub   = 1'b0;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = LOAD;
            LOAD: begin
                dp_load = 1'b1;
                state_d = (dr_in == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                dp_shift = 1'b1;
                state_d  = SUB;
            end
            SUB: begin
                dp_sub  = 1'b1;
                state_d = dp_last ? DONE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result and status registers; Q/R only change on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (dr_in == '0) begin
                        quo_q  <= DZ_Q;
                        rem_q  <= DZ_R;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                SUB: begin
                    if (dp_last) begin
                        quo_q  <= quo_nxt;
                        rem_q  <= rem_nxt;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    div_4_dp u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (dp_load),
        .shift  (dp_shift),
        .sub    (dp_sub),
        .dd     (ui_in),
        .dr     (dr_in),
        .last   (dp_last),
        .quo_nxt(quo_nxt),
        .rem_nxt(rem_nxt)
    );

    assign uo_out  = quo_q;
    assign uio_out = {rem_q, 1'b0, err_q, done_q, 1'b0};
    assign uio_oe  = 8'b1111_0110;

endmodule

// File: tb/tb_tt_um_div_4.sv
// Self-checking bench for tt_um_div_4: directed corner cases then random
// operands against an arithmetic reference (/ and %).
module tb_tt_um_div_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       ena;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Last result the bench expects the outputs to be holding.
    logic [7:0] prev_q;
    logic [3:0] prev_r;

    tt_um_div_4 dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .ena    (ena),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic done, input logic err,
                             input logic [7:0] q, input logic [3:0] r);
        check({tag, "/q"},   uo_out,  q);
        check({tag, "/uio"}, uio_out, {r, 1'b0, err, done, 1'b0});
        check({tag, "/oe"},  uio_oe,  8'hF6);
    endtask

    // Start an operation and follow it to completion. hold = cycles init stays
    // high; glitch_at = edge number before which a second init pulse is
    // raised (-1 for none). Operands are scrambled after LOAD to prove capture.
    task automatic do_op(input logic [7:0] dd, input logic [3:0] dr,
                         input int hold, input int glitch_at, input string tag);
        logic [7:0] exp_q;
        logic [3:0] exp_r;
        int         last;
        logic [7:0] tmp8;
        logic [3:0] tmp4;
        if (dr == 4'd0) begin
            exp_q = 8'hFF;
            exp_r = 4'hF;
            last  = 1;
        end else begin
            exp_q = dd / dr;
            exp_r = 4'(dd % dr);
            last  = 17;
        end
        ui_in  = dd;
        uio_in = {dr, 3'b000, 1'b1};
        for (int e = 0; e <= last; e++) begin
            tick();
            if (e + 1 >= hold) uio_in[0] = 1'b0;
            if (e == 1) begin
                tmp8 = 8'($urandom);
                tmp4 = 4'($urandom);
                ui_in       = tmp8;
                uio_in[7:4] = tmp4;
            end
            if (e + 1 == glitch_at) uio_in[0] = 1'b1;
            if (e == glitch_at)     uio_in[0] = 1'b0;
            if (e >= 1 && e < last && (e == 1 || e == last - 1))
                check_out($sformatf("%s/busy%0d", tag, e), 1'b0, 1'b0, prev_q, prev_r);
        end
        check_out({tag, "/done"}, 1'b1, dr == 4'd0, exp_q, exp_r);
        prev_q = exp_q;
        prev_r = exp_r;
    endtask

    initial begin
        rst    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        prev_q = 8'h00;
        prev_r = 4'h0;
        tick();
        tick();
        check_out("reset", 1'b0, 1'b0, 8'h00, 4'h0);
        rst = 1'b0;
        tick();
        check_out("idle", 1'b0, 1'b0, 8'h00, 4'h0);

        // Directed operand cases.
        do_op(8'd195, 4'd7,  1, -1, "195/7");
        do_op(8'd255, 4'd1,  1, -1, "255/1");
        do_op(8'd3,   4'd15, 1, -1, "3/15");
        do_op(8'd9,   4'd0,  1, -1, "9/0");
        do_op(8'd0,   4'd5,  1, -1, "0/5");

        // Held init plus a second pulse during SUB of iteration 3.
        do_op(8'd200, 4'd11, 2, 7, "held_glitch");
        for (int i = 0; i < 5; i++) tick();
        check_out("done_hold", 1'b1, 1'b0, prev_q, prev_r);

        // Reset at edge 8 of an operation.
        ui_in  = 8'd100;
        uio_in = {4'd9, 3'b000, 1'b1};
        for (int e = 0; e <= 7; e++) begin
            tick();
            uio_in[0] = 1'b0;
        end
        rst = 1'b1;
        tick();
        check_out("mid_rst", 1'b0, 1'b0, 8'h00, 4'h0);
        rst = 1'b0;
        tick();
        check_out("post_rst", 1'b0, 1'b0, 8'h00, 4'h0);
        prev_q = 8'h00;
        prev_r = 4'h0;
        do_op(8'd200, 4'd13, 1, -1, "after_rst");

        // Back-to-back start from DONE with new operands.
        do_op(8'd77, 4'd4, 1, -1, "b2b");

        // Init already high while reset is released.
        rst    = 1'b1;
        ui_in  = 8'd50;
        uio_in = {4'd6, 3'b000, 1'b1};
        tick();
        rst    = 1'b0;
        prev_q = 8'h00;
        prev_r = 4'h0;
        do_op(8'd50, 4'd6, 1, -1, "rst_init");

        // Random operands, divisor zero included in the range.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] rdd;
            logic [3:0] rdr;
            rdd = 8'($urandom);
            rdr = 4'($urandom_range(0, 15));
            do_op(rdd, rdr, 1, -1, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
